// File: rtl/botsw_nonoverlap_ctrl_pkg.sv
// Shared types and helpers for the buck non-overlap controller.
package botsw_ctrl_pkg;

  localparam int DT_W_DEF = 4;
  localparam int MB_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOP_ON = 3'd1,
    ST_DT_TB  = 3'd2,
    ST_BOT_ON = 3'd3,
    ST_DT_BT  = 3'd4,
    ST_FLT    = 3'd5
  } state_t;

  // A programmed dead time of 0 still yields one both-off cycle.
  function automatic int unsigned eff_dt(input int unsigned dt);
    return (dt == 0) ? 1 : dt;
  endfunction

endpackage

// File: rtl/botsw_nonoverlap_ctrl_if.sv
// Control/status bundle between the PWM loop and the non-overlap controller.
interface botsw_nonoverlap_ctrl_if #(
  parameter int DT_W = botsw_ctrl_pkg::DT_W_DEF
) ();
  logic            EN;
  logic            PWM;
  logic            ZCD;
  logic            FAULT;
  logic            CLR_FAULT;
  logic [DT_W-1:0] DT_TB;
  logic [DT_W-1:0] DT_BT;
  logic            TOP_EN;
  logic            BOT_EN;
  logic            FAULT_LATCH;
  logic [2:0]      STATE;

  modport master (
    output EN, PWM, ZCD, FAULT, CLR_FAULT, DT_TB, DT_BT,
    input  TOP_EN, BOT_EN, FAULT_LATCH, STATE
  );

  modport slave (
    input  EN, PWM, ZCD, FAULT, CLR_FAULT, DT_TB, DT_BT,
    output TOP_EN, BOT_EN, FAULT_LATCH, STATE
  );
endinterface

// File: rtl/botsw_nonoverlap_ctrl_dt_timer.sv
// Loadable down-counter used for both dead-time intervals.
module dt_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] VAL,
  output logic         DONE
);
  logic [W-1:0] cnt;

  // Load wins over counting; the counter parks at 0 once expired.
  always_ff @(posedge CLK) begin
    if (RST)              cnt <= '0;
    else if (LOAD)        cnt <= VAL;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign DONE = (cnt == W'(1));
endmodule

// File: rtl/botsw_nonoverlap_ctrl.sv
// Non-overlap controller: PWM -> registered top/bottom enables with dead
// times, bottom min-on, diode emulation and a sticky fault latch.
module botsw_nonoverlap_ctrl
  import botsw_ctrl_pkg::*;
#(
  parameter int DT_W    = DT_W_DEF,
  parameter int MIN_BOT = 2,
  parameter int MB_W    = MB_W_DEF
) (
  input logic                   CLK,
  input logic                   RST,
  botsw_nonoverlap_ctrl_if.slave bus
);
  state_t          state, nxt;
  logic [MB_W-1:0] mb_cnt;
  logic            mb_done;
  logic            dt_load, dt_done;
  logic [DT_W-1:0] dt_val;
  logic            top_q, bot_q, flt_q;

  // Exit is allowed in the last min-on cycle so BOT_EN is high exactly
  // MIN_BOT cycles when a stop condition is already present on entry.
  assign mb_done = (mb_cnt <= MB_W'(1));

  dt_timer #(.W(DT_W)) u_dt (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (dt_load),
    .VAL  (dt_val),
    .DONE (dt_done)
  );

  // Next-state and dead-time load; FAULT overrides everything but RST.
  always_comb begin
    nxt     = state;
    dt_load = 1'b0;
    dt_val  = '0;
    if (bus.FAULT) begin
      nxt = ST_FLT;
    end else begin
      case (state)
        ST_IDLE:   if (bus.EN && bus.PWM) nxt = ST_TOP_ON;
        ST_TOP_ON: if (!bus.PWM || !bus.EN) begin
          nxt     = ST_DT_TB;
          dt_load = 1'b1;
          dt_val  = DT_W'(eff_dt(32'(bus.DT_TB)));
        end
        ST_DT_TB:  if (dt_done) begin
          if (!bus.EN)      nxt = ST_IDLE;
          else if (bus.PWM) nxt = ST_TOP_ON;
          else if (bus.ZCD) nxt = ST_IDLE;   // DCM: skip bottom pulse
          else              nxt = ST_BOT_ON;
        end
        ST_BOT_ON: if (mb_done && (bus.PWM || bus.ZCD || !bus.EN)) begin
          nxt     = ST_DT_BT;
          dt_load = 1'b1;
          dt_val  = DT_W'(eff_dt(32'(bus.DT_BT)));
        end
        ST_DT_BT:  if (dt_done) nxt = (bus.EN && bus.PWM) ? ST_TOP_ON : ST_IDLE;
        ST_FLT:    if (bus.CLR_FAULT) nxt = ST_IDLE;  // FAULT is 0 here
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers; outputs decode the next state so they
  // change together with STATE and never glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      top_q <= 1'b0;
      bot_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      state <= nxt;
      top_q <= (nxt == ST_TOP_ON);
      bot_q <= (nxt == ST_BOT_ON);
      flt_q <= (nxt == ST_FLT);
    end
  end

  // Bottom min-on counter, loaded on BOT_ON entry.
  always_ff @(posedge CLK) begin
    if (RST)                                         mb_cnt <= '0;
    else if (nxt == ST_BOT_ON && state != ST_BOT_ON) mb_cnt <= MB_W'(MIN_BOT);
    else if (state == ST_BOT_ON && mb_cnt != '0)     mb_cnt <= mb_cnt - 1'b1;
  end

  assign bus.TOP_EN      = top_q;
  assign bus.BOT_EN      = bot_q;
  assign bus.FAULT_LATCH = flt_q;
  assign bus.STATE       = state;
endmodule

// File: tb/tb_botsw_nonoverlap_ctrl.sv
// Directed bench for the non-overlap controller.
module tb_botsw_nonoverlap_ctrl;
  import botsw_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  botsw_nonoverlap_ctrl_if #(.DT_W(4)) bus ();

  botsw_nonoverlap_ctrl #(.DT_W(4), .MIN_BOT(2), .MB_W(3)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // n cycles, each expected to land in state st; enables follow from st.
  task automatic run(input int n, input logic [2:0] st, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_st"},  32'(bus.STATE),       32'(st));
      chk({tag, "_top"}, 32'(bus.TOP_EN),      32'(st == 3'd1));
      chk({tag, "_bot"}, 32'(bus.BOT_EN),      32'(st == 3'd3));
      chk({tag, "_flt"}, 32'(bus.FAULT_LATCH), 32'(st == 3'd5));
    end
  endtask

  // Both enables high together is never allowed.
  always @(negedge CLK) chk("overlap", 32'(bus.TOP_EN & bus.BOT_EN), 32'd0);

  initial begin
    RST = 1'b1;
    bus.EN = 1'b0; bus.PWM = 1'b0; bus.ZCD = 1'b0;
    bus.FAULT = 1'b0; bus.CLR_FAULT = 1'b0;
    bus.DT_TB = 4'd3; bus.DT_BT = 4'd2;
    run(2, ST_IDLE, "reset");

    // CCM cycle
    RST = 1'b0; bus.EN = 1'b1; bus.PWM = 1'b1;
    run(10, ST_TOP_ON, "ccm_top");
    bus.PWM = 1'b0;
    run(3, ST_DT_TB,  "ccm_dtb");
    run(7, ST_BOT_ON, "ccm_bot");
    bus.PWM = 1'b1;
    run(2, ST_DT_BT,  "ccm_dbt");
    run(3, ST_TOP_ON, "ccm_top2");

    // zero dead-time programming still gives one both-off cycle
    bus.DT_TB = 4'd0; bus.DT_BT = 4'd0; bus.PWM = 1'b0;
    run(1, ST_DT_TB,  "zdt_tb");
    run(3, ST_BOT_ON, "zdt_bot");
    bus.PWM = 1'b1;
    run(1, ST_DT_BT,  "zdt_bt");
    run(2, ST_TOP_ON, "zdt_top");

    // DCM: ZCD in first bottom cycle, min-on holds 2 cycles
    bus.DT_TB = 4'd2; bus.DT_BT = 4'd1; bus.PWM = 1'b0;
    run(2, ST_DT_TB,  "dcm_dtb");
    run(1, ST_BOT_ON, "dcm_bot1");
    bus.ZCD = 1'b1;
    run(1, ST_BOT_ON, "dcm_bot2");
    run(1, ST_DT_BT,  "dcm_dbt");
    run(2, ST_IDLE,   "dcm_idle");

    // DCM skip: ZCD at dead-time expiry suppresses the bottom pulse
    bus.ZCD = 1'b0; bus.PWM = 1'b1;
    run(1, ST_TOP_ON, "skip_top");
    bus.PWM = 1'b0; bus.ZCD = 1'b1;
    run(2, ST_DT_TB,  "skip_dtb");
    run(3, ST_IDLE,   "skip_idle");
    bus.ZCD = 1'b0;

    // PWM glitch: full 4-cycle dead time, DT_TB change mid-count ignored
    bus.DT_TB = 4'd4; bus.PWM = 1'b1;
    run(2, ST_TOP_ON, "gl_top");
    bus.PWM = 1'b0;
    run(1, ST_DT_TB,  "gl_dtb0");
    bus.PWM = 1'b1; bus.DT_TB = 4'd0;
    run(3, ST_DT_TB,  "gl_dtb");
    run(2, ST_TOP_ON, "gl_top2");

    // simultaneous PWM and ZCD after min-on: single DT_BT
    bus.DT_TB = 4'd1; bus.DT_BT = 4'd3; bus.PWM = 1'b0;
    run(1, ST_DT_TB,  "sim_dtb");
    run(2, ST_BOT_ON, "sim_bot");
    bus.PWM = 1'b1; bus.ZCD = 1'b1;
    run(3, ST_DT_BT,  "sim_dbt");
    bus.ZCD = 1'b0;
    run(1, ST_TOP_ON, "sim_top");

    // fault during bottom min-on
    bus.PWM = 1'b0;
    run(1, ST_DT_TB,  "flt_dtb");
    run(1, ST_BOT_ON, "flt_bot");
    bus.FAULT = 1'b1;
    run(1, ST_FLT,    "flt_set");
    bus.CLR_FAULT = 1'b1;
    run(2, ST_FLT,    "flt_clr_ign");
    bus.FAULT = 1'b0; bus.PWM = 1'b1;
    run(1, ST_IDLE,   "flt_clr");
    bus.CLR_FAULT = 1'b0;
    run(1, ST_TOP_ON, "flt_top");

    // reset mid-TOP_ON drops enables on the same edge
    RST = 1'b1;
    run(1, ST_IDLE,   "rst_mid");
    RST = 1'b0;
    run(1, ST_TOP_ON, "rst_top");

    // EN drop during bottom min-on
    bus.DT_BT = 4'd2; bus.PWM = 1'b0;
    run(1, ST_DT_TB,  "en_dtb");
    run(1, ST_BOT_ON, "en_bot");
    bus.EN = 1'b0;
    run(1, ST_BOT_ON, "en_hold");
    run(2, ST_DT_BT,  "en_dbt");
    run(2, ST_IDLE,   "en_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/botsw_nonoverlap_ctrl.md
Name: botsw_nonoverlap_ctrl

Overview:
- Digital non-overlap controller for the step-down power stage. Converts the loop PWM into registered top-switch and bottom-switch drive enables, TOP_EN and BOT_EN.
- Inserts programmable dead times, enforces a bottom-switch minimum on-time, and performs diode emulation: bottom switch off on zero-cross.
- Feeds the bottom-switch driver chain and its passive pulldown network, and the top driver.
- Latches faults and holds both switches off until the fault is cleared.

Parameters:
- DT_W, 4: width of the dead-time programming inputs and of the dead-time counter.
- MIN_BOT, 2: minimum BOT_EN high time in cycles, ≥1.
- MB_W, 3: width of the min-on counter; must satisfy MIN_BOT < 2**MB_W.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous active-high reset
- EN  in  1  converter enable
- PWM  in  1  loop PWM, already synchronous to CLK; 1 = top phase requested
- ZCD  in  1  inductor zero-cross flag, synchronous; 1 = current ≤ 0
- FAULT  in  1  synchronous fault request (OCP/UVLO)
- CLR_FAULT  in  1  fault-latch clear
- DT_TB  in  DT_W  top-off to bottom-on dead time, cycles
- DT_BT  in  DT_W  bottom-off to top-on dead time, cycles
- TOP_EN  out  1  top switch gate enable, registered
- BOT_EN  out  1  bottom switch gate enable, registered
- FAULT_LATCH  out  1  sticky fault flag
- STATE  out  3  current FSM state encoding, for debug

Behaviour:
- Reset (RST=1 at a CLK edge):
  - TOP_EN=0, BOT_EN=0, FAULT_LATCH=0, STATE=IDLE, all counters 0.
  - RST mid-operation drops both enables on that same edge.
- Invariant: TOP_EN & BOT_EN is never 1. Every on-to-on transfer between switches passes through a dead-time state with both enables 0.
- All outputs are registered. An input change is reflected on the outputs 1 cycle later.
- Effective dead time = max(DT_xx, 1) cycles. DT_xx is sampled on entry to the dead-time state; later changes do not affect the current count.
- States, with encoding in the package: IDLE=0, TOP_ON=1, DT_TB=2, BOT_ON=3, DT_BT=4, FLT=5.
- IDLE (both off):
  - EN & PWM -> TOP_ON.
  - Entry to IDLE always follows ≥1 cycle with BOT_EN=0, so the bottom-to-top dead time is already satisfied.
- TOP_ON (TOP_EN=1):
  - !PWM or !EN -> DT_TB, loading the counter with max(DT_TB,1).
- DT_TB (both off): counter decrements each cycle. At count==1:
  - !EN -> IDLE.
  - PWM=1 (re-request) -> TOP_ON.
  - ZCD=1 -> IDLE (DCM skip: bottom pulse suppressed).
  - Otherwise -> BOT_ON, loading the min-on counter with MIN_BOT.
- BOT_ON (BOT_EN=1):
  - The min-on counter decrements each cycle. PWM, ZCD and EN are ignored until it reaches 0; FAULT is not.
  - After that, PWM | ZCD | !EN -> DT_BT, loading max(DT_BT,1).
  - Simultaneous PWM and ZCD: a single DT_BT is taken.
- DT_BT (both off): at count==1:
  - EN & PWM -> TOP_ON.
  - Otherwise -> IDLE.
- FAULT:
  - Highest priority after RST. FAULT=1 in any state gives next cycle STATE=FLT, TOP_EN=0, BOT_EN=0, FAULT_LATCH=1. The min-on time is overridden.
  - In FLT: CLR_FAULT & !FAULT -> IDLE with FAULT_LATCH=0; otherwise stay.
  - CLR_FAULT while FAULT=1 has no effect.
- Priority order: RST > FAULT > EN deassert > PWM/ZCD.

Decomposition:
- Package botsw_ctrl_pkg holds:
  - the state enum and its 3-bit encodings;
  - the DT_W and MB_W defaults;
  - a function for effective dead time, max(dt,1).
- Sub-module dt_timer: a loadable down-counter with parameter W and ports CLK, RST, LOAD, VAL, DONE. DONE asserts in the cycle the count is 1.
- dt_timer is instantiated once for the dead time. The min-on counter stays inline.

Test Plan:
- CCM cycle (DT_TB=3, DT_BT=2, ZCD=0, EN=1): PWM high 10 cycles then low 10 -> TOP_EN high 10, then 3 cycles both low, then BOT_EN high until PWM rises, then 2 cycles both low, then TOP_EN. Assert no overlap in any cycle.
- Zero dead-time programming (DT_TB=0, DT_BT=0): exactly 1 both-off cycle at each transition.
- DCM (MIN_BOT=2): ZCD asserted in the 1st BOT_ON cycle -> BOT_EN stays high 2 cycles, then DT_BT, then IDLE. With ZCD=1 at DT_TB expiry -> BOT_EN never rises.
- PWM glitch: PWM low for 1 cycle during TOP_ON with DT_TB=4 -> full 4-cycle dead time, then back to TOP_ON; BOT_EN stays 0.
- Fault in BOT_ON during min-on: FAULT pulse -> next cycle both 0, FAULT_LATCH=1, STATE=5.
  - CLR_FAULT with FAULT=1 is ignored.
  - CLR_FAULT with FAULT=0 -> IDLE, then TOP_ON if PWM=1.
- Reset mid-TOP_ON and EN drop mid-BOT_ON:
  - RST -> both 0 on the same edge.
  - EN=0 -> BOT_EN held for the remaining min-on, then DT_BT, then IDLE.
